// File: rtl/mic_array_xcorr_pkg.sv
// Shared definitions for the multi-mic cross-correlator.
//   state_t    : controller states
//   DEF_*      : default sample width, window depth and lag range
//   acc_width  : accumulator width that cannot overflow for a full window
package mic_array_xcorr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_MAC,
    S_EVAL,
    S_EMIT,
    S_DONE
  } state_t;

  localparam int DEF_DW     = 16;
  localparam int DEF_WIN    = 256;
  localparam int DEF_LAGNUM = 10;

  function automatic int acc_width(int dw, int win);
    return 2 * dw + $clog2(win);
  endfunction

endpackage

// File: rtl/mic_win_ram.sv
// Simple dual-port sample window memory, one write port and one read port,
// registered read data (1-cycle latency).
//   clk      : clock
//   wr_en    : write wr_data at wr_addr
//   rd_addr  : read address, data appears on rd_data next cycle
module mic_win_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mic_array_xcorr.sv
// Sliding-window cross-correlator: captures NCH parallel PCM channels into a
// WIN-deep window and, on request, finds for each channel k=1..NCH-1 the lag in
// [-LAGNUM,+LAGNUM] maximising sum x0[n]*xk[n+lag].
//   clk_60MHz, rst_n          : clock, async active-low reset
//   smp_valid, smp_data       : one sample per channel, ch c at [c*DW +: DW]
//   start                     : run request pulse
//   busy, done, drop          : run status, completion pulse, sticky overrun
//   res_valid/res_ready       : result handshake
//   res_ch, res_lag, res_peak : channel, best lag, correlation at best lag
module mic_array_xcorr
  import mic_array_xcorr_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DW     = DEF_DW,
  parameter int WIN    = DEF_WIN,
  parameter int LAGNUM = DEF_LAGNUM,
  parameter int LAGW   = 6,
  parameter int ACCW   = acc_width(DW, WIN)
) (
  input  logic                     clk_60MHz,
  input  logic                     rst_n,
  input  logic                     smp_valid,
  input  logic [NCH*DW-1:0]        smp_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     drop,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(NCH)-1:0]   res_ch,
  output logic signed [LAGW-1:0]   res_lag,
  output logic signed [ACCW-1:0]   res_peak
);

  localparam int AW   = $clog2(WIN);
  localparam int CW   = $clog2(NCH);
  localparam int FW   = AW + 1;
  localparam int NMAC = WIN - 2 * LAGNUM;
  localparam int CNTW = $clog2(NMAC + 1);

  localparam logic signed [LAGW-1:0] LAG_MIN  = LAGW'(-LAGNUM);
  localparam logic signed [LAGW-1:0] LAG_MAX  = LAGW'(LAGNUM);
  localparam logic [CNTW-1:0]        CNT_LAST = CNTW'(NMAC);
  localparam logic [CW-1:0]          CH_LAST  = CW'(NCH - 1);

  state_t                  state, state_nxt;
  logic [AW-1:0]           wr_ptr, base;
  logic [FW-1:0]           fill;
  logic                    fill_full, wr_en, start_ok, begin_mac;
  logic [CNTW-1:0]         cnt;
  logic signed [LAGW-1:0]  lag, best_lag, sel_lag;
  logic [CW-1:0]           ch;
  logic                    rd_vld, upd;
  logic [AW-1:0]           rd_ref, rd_k;
  logic signed [DW-1:0]    ram_q [NCH];
  logic signed [DW-1:0]    ram_k;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACCW-1:0]  acc, best, sel_peak;

  assign fill_full = (fill == FW'(WIN));
  assign wr_en     = smp_valid && !busy;

  // Window index n maps to (base+n) mod WIN; AW-bit arithmetic wraps for free.
  assign rd_ref = base + AW'(LAGNUM) + AW'(cnt);
  assign rd_k   = rd_ref + AW'(lag);

  for (genvar c = 0; c < NCH; c++) begin : g_ram
    mic_win_ram #(.WIDTH(DW), .DEPTH(WIN)) u_ram (
      .clk     (clk_60MHz),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (smp_data[c*DW +: DW]),
      .rd_addr ((c == 0) ? rd_ref : rd_k),
      .rd_data (ram_q[c])
    );
  end

  always_comb begin
    ram_k = ram_q[1];
    for (int unsigned c = 1; c < NCH; c++)
      if (ch == CW'(c)) ram_k = ram_q[c];
  end

  assign prod = ram_q[0] * ram_k;

  // First lag always loads; later lags replace only when strictly greater.
  assign upd      = (lag == LAG_MIN) || (acc > best);
  assign sel_peak = upd ? acc : best;
  assign sel_lag  = upd ? lag : best_lag;

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    begin_mac = 1'b0;
    unique case (state)
      S_IDLE: if (start) begin
        start_ok = 1'b1;
        if (fill_full) begin
          state_nxt = S_MAC;
          begin_mac = 1'b1;
        end else begin
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: if (fill_full) begin
        state_nxt = S_MAC;
        begin_mac = 1'b1;
      end
      S_MAC:  if (cnt == CNT_LAST) state_nxt = S_EVAL;
      S_EVAL: state_nxt = (lag == LAG_MAX) ? S_EMIT : S_MAC;
      S_EMIT: if (res_ready) state_nxt = (ch == CH_LAST) ? S_DONE : S_MAC;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state == S_MAC) || (state == S_EVAL) ||
                     (state == S_EMIT) || (state == S_DONE);
  assign res_valid = (state == S_EMIT);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      fill     <= '0;
      base     <= '0;
      cnt      <= '0;
      lag      <= '0;
      ch       <= '0;
      rd_vld   <= 1'b0;
      acc      <= '0;
      best     <= '0;
      best_lag <= '0;
      drop     <= 1'b0;
      res_ch   <= '0;
      res_lag  <= '0;
      res_peak <= '0;
    end else begin
      state  <= state_nxt;
      rd_vld <= (state == S_MAC) && (cnt != CNT_LAST);

      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (wr_en && !fill_full) fill <= fill + FW'(1);

      if (smp_valid && busy) drop <= 1'b1;
      else if (start_ok)     drop <= 1'b0;

      // A sample captured in the same cycle becomes the newest, so the
      // oldest entry then sits one slot past the current write pointer.
      if (begin_mac) begin
        base <= wr_en ? wr_ptr + AW'(1) : wr_ptr;
        ch   <= CW'(1);
        lag  <= LAG_MIN;
        cnt  <= '0;
        acc  <= '0;
      end

      if (state == S_MAC && cnt != CNT_LAST) cnt <= cnt + CNTW'(1);
      if (rd_vld) acc <= acc + ACCW'(prod);

      if (state == S_EVAL) begin
        best     <= sel_peak;
        best_lag <= sel_lag;
        acc      <= '0;
        cnt      <= '0;
        if (lag == LAG_MAX) begin
          res_ch   <= ch;
          res_lag  <= sel_lag;
          res_peak <= sel_peak;
        end else begin
          lag <= lag + LAGW'(1);
        end
      end

      if (state == S_EMIT && res_ready && ch != CH_LAST) begin
        ch  <= ch + CW'(1);
        lag <= LAG_MIN;
      end
    end
  end

endmodule

// File: tb/tb_mic_array_xcorr.sv
module tb_mic_array_xcorr;

  localparam int NCH  = 3;
  localparam int DW   = 16;
  localparam int WIN  = 64;
  localparam int L    = 4;
  localparam int LAGW = 6;
  localparam int ACCW = 2 * DW + 6;
  localparam int CW   = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   smp_valid = 1'b0;
  logic [NCH*DW-1:0]      smp_data = '0;
  logic                   start = 1'b0;
  logic                   busy, done, drop, res_valid;
  logic                   res_ready = 1'b0;
  logic [CW-1:0]          res_ch;
  logic signed [LAGW-1:0] res_lag;
  logic signed [ACCW-1:0] res_peak;

  int x [NCH][WIN];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mic_array_xcorr #(
    .NCH(NCH), .DW(DW), .WIN(WIN), .LAGNUM(L), .LAGW(LAGW), .ACCW(ACCW)
  ) dut (
    .clk_60MHz (clk),
    .rst_n     (rst_n),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .drop      (drop),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ch    (res_ch),
    .res_lag   (res_lag),
    .res_peak  (res_peak)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- pattern setup and reference model ----------------
  task automatic set_all(input int v0, input int vk);
    for (int c = 0; c < NCH; c++)
      for (int n = 0; n < WIN; n++) x[c][n] = (c == 0) ? v0 : vk;
  endtask

  task automatic set_impulse();
    set_all(0, 0);
    x[0][32] = 100;
    x[1][30] = 100;
    x[2][35] = 100;
  endtask

  task automatic set_delay();
    int s [WIN+3];
    for (int i = 0; i < WIN + 3; i++) s[i] = int'($urandom_range(2000)) - 1000;
    for (int n = 0; n < WIN; n++) begin
      x[0][n] = s[n+3];
      x[1][n] = s[n];
      x[2][n] = s[n+3];
    end
  endtask

  function automatic longint model_peak(int k, int lag);
    longint s = 0;
    for (int n = L; n <= WIN - L - 1; n++)
      s += longint'(x[0][n]) * longint'(x[k][n+lag]);
    return s;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; smp_valid = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feed(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      @(negedge clk);
      smp_valid = 1'b1;
      for (int c = 0; c < NCH; c++) smp_data[c*DW +: DW] = DW'(x[c][i]);
    end
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_result(input string name, input int k, input int exp_lag,
                               input longint exp_peak, input int hold);
    int t = 0;
    logic stable = 1'b1;
    logic [CW-1:0] h_ch;
    logic signed [LAGW-1:0] h_lag;
    logic signed [ACCW-1:0] h_peak;
    while (res_valid !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    total_cnt++;
    if (res_valid !== 1'b1) begin
      $display("FAIL %s_timeout: res_valid=%b after %0d cycles, required 1", name, res_valid, t);
      return;
    end
    pass_cnt++;
    total_cnt++;
    if (res_ch !== CW'(k)) $display("FAIL %s_ch: got %0d required %0d", name, res_ch, k);
    else pass_cnt++;
    total_cnt++;
    if (res_lag !== LAGW'(exp_lag))
      $display("FAIL %s_lag: got %0d required %0d", name, res_lag, exp_lag);
    else pass_cnt++;
    total_cnt++;
    if (res_peak !== ACCW'(exp_peak))
      $display("FAIL %s_peak: got %0d required %0d", name, res_peak, exp_peak);
    else pass_cnt++;
    if (hold > 0) begin
      h_ch = res_ch; h_lag = res_lag; h_peak = res_peak;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || done !== 1'b0 || res_ch !== h_ch ||
            res_lag !== h_lag || res_peak !== h_peak) stable = 1'b0;
      end
      total_cnt++;
      if (stable !== 1'b1) $display("FAIL %s_hold: stable=%b required 1", name, stable);
      else pass_cnt++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total_cnt++;
    if (res_valid !== 1'b0 || done !== (k == NCH - 1))
      $display("FAIL %s_accept: res_valid=%b done=%b required 0 %b",
               name, res_valid, done, (k == NCH - 1));
    else pass_cnt++;
    if (k == NCH - 1) begin
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL %s_end: busy=%b done=%b required 0 0", name, busy, done);
      else pass_cnt++;
    end
  endtask

  task automatic check_busy_after_start(input string name);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s_busy: got %b required 1", name, busy);
    else pass_cnt++;
  endtask

  task automatic check_idle_outputs(input string name);
    total_cnt++;
    if ({busy, done, drop, res_valid} !== 4'b0 || res_ch !== '0 ||
        res_lag !== '0 || res_peak !== '0)
      $display("FAIL %s: busy/done/drop/valid=%b%b%b%b ch=%0d lag=%0d peak=%0d required all 0",
               name, busy, done, drop, res_valid, res_ch, res_lag, res_peak);
    else pass_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset");
  endtask

  task automatic test_impulse();
    set_impulse();
    feed(0, WIN);
    pulse_start();
    check_busy_after_start("impulse");
    expect_result("impulse_ch1", 1, -2, 10000, 0);
    expect_result("impulse_ch2", 2, 3, 10000, 0);
  endtask

  task automatic test_rerun();
    pulse_start();
    check_busy_after_start("rerun");
    expect_result("rerun_ch1", 1, -2, 10000, 0);
    expect_result("rerun_ch2", 2, 3, 10000, 0);
  endtask

  task automatic test_zero();
    set_all(0, 0);
    feed(0, WIN);
    pulse_start();
    expect_result("zero_ch1", 1, -L, 0, 0);
    expect_result("zero_ch2", 2, -L, 0, 0);
  endtask

  task automatic test_const();
    set_all(1, -1);
    feed(0, WIN);
    pulse_start();
    expect_result("const_ch1", 1, -L, -56, 0);
    expect_result("const_ch2", 2, -L, -56, 0);
  endtask

  task automatic test_delay(input string name);
    set_delay();
    feed(0, WIN);
    pulse_start();
    expect_result({name, "_ch1"}, 1, 3, model_peak(1, 3), 0);
    expect_result({name, "_ch2"}, 2, 0, model_peak(2, 0), 0);
  endtask

  task automatic test_arming();
    logic idle_ok = 1'b1;
    do_reset();
    set_impulse();
    feed(0, 10);
    pulse_start();
    for (int i = 10; i < WIN; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) idle_ok = 1'b0;
      smp_valid = 1'b1;
      for (int c = 0; c < NCH; c++) smp_data[c*DW +: DW] = DW'(x[c][i]);
    end
    @(negedge clk);
    smp_valid = 1'b0;
    if (busy !== 1'b0) idle_ok = 1'b0;
    total_cnt++;
    if (idle_ok !== 1'b1) $display("FAIL arming_wait: busy seen before window full");
    else pass_cnt++;
    @(negedge clk);
    check_busy_after_start("arming");
    smp_valid = 1'b1;
    smp_data = '1;
    repeat (3) @(negedge clk);
    smp_valid = 1'b0;
    total_cnt++;
    if (drop !== 1'b1) $display("FAIL arming_drop: got %b required 1", drop);
    else pass_cnt++;
    expect_result("arming_ch1", 1, -2, 10000, 0);
    expect_result("arming_ch2", 2, 3, 10000, 0);
  endtask

  task automatic test_backpressure();
    pulse_start();
    total_cnt++;
    if (drop !== 1'b0) $display("FAIL bp_drop_clear: got %b required 0", drop);
    else pass_cnt++;
    expect_result("bp_ch1", 1, -2, 10000, 50);
    expect_result("bp_ch2", 2, 3, 10000, 50);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    repeat (100) @(negedge clk);
    smp_valid = 1'b1;
    repeat (2) @(negedge clk);
    smp_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_mid");
    rst_n = 1'b1;
    pulse_start();
    repeat (5) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_mid_fill: busy=%b required 0", busy);
    else pass_cnt++;
    set_delay();
    feed(0, WIN);
    expect_result("reset_mid_ch1", 1, 3, model_peak(1, 3), 0);
    expect_result("reset_mid_ch2", 2, 0, model_peak(2, 0), 0);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_rerun();
    test_zero();
    test_const();
    test_delay("delay");
    test_arming();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
